// File: rtl/ysyx_22040237_ifu.sv
// rtl/ysyx_22040237_ifu.sv - instruction fetch stage: PC owner, single-outstanding imem fetch, one-entry output buffer
//
// Purpose:
//   Owns the architectural PC and fetches one instruction at a time from
//   instruction memory. The fetched word is held in a one-entry buffer and
//   offered to decode as {out_pc, out_inst}. Control-flow redirects from
//   execute replace the sequential PC, and a halt stops all further fetching
//   until reset.
//
// Ports:
//   clk              in   1   clock, all state on posedge
//   rst_n            in   1   asynchronous active-low reset
//   imem_req_valid   out  1   fetch request valid
//   imem_req_ready   in   1   memory accepts the request
//   imem_req_addr    out  64  fetch address (4-byte aligned)
//   imem_resp_valid  in   1   response valid, one per accepted request
//   imem_resp_data   in   32  fetched instruction word
//   out_valid        out  1   {out_pc, out_inst} valid to decode
//   out_ready        in   1   decode consumes the buffered instruction
//   out_pc           out  64  PC of out_inst
//   out_inst         out  32  buffered instruction word
//   redirect_valid   in   1   jump taken this cycle
//   redirect_pc      in   64  jump target, low two bits ignored
//   halt             in   1   stop fetching, sticky until reset

module ysyx_22040237_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL,
    S_HALTED
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  state_t      w_fetch_state;

  logic [63:0] r_pc;
  logic [63:0] r_req_addr;
  logic        r_kill;
  logic        r_halted;
  logic [63:0] r_out_pc;
  logic [31:0] r_out_inst;

  logic [63:0] w_redirect_pc;
  logic [63:0] w_pc_cur;
  logic [63:0] w_seq_pc;
  logic [63:0] w_pc_next;
  logic [63:0] w_req_addr_next;
  logic        w_req_load;
  logic        w_kill_next;
  logic        w_capture;
  logic        w_halt_any;

  // Redirect targets are word aligned by dropping the low two bits.
  assign w_redirect_pc = redirect_pc & ~64'h3;

  // PC as seen this cycle: a redirect overrides whatever is stored.
  assign w_pc_cur = redirect_valid ? w_redirect_pc : r_pc;

  // Sequential successor of the buffered instruction; wraps modulo 2^64.
  assign w_seq_pc = r_out_pc + 64'd4;

  // A halt arriving in the same cycle as a fetch decision already blocks
  // the next request, so the registered flag and the live input are merged.
  assign w_halt_any    = r_halted | halt;
  assign w_fetch_state = w_halt_any ? S_HALTED : S_REQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = w_pc_cur;
    w_req_load      = 1'b0;
    w_req_addr_next = w_pc_cur;
    w_kill_next     = r_kill;
    w_capture       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_req_load   = 1'b1;
        w_state_next = w_fetch_state;
      end

      S_REQ: begin
        // The request already on the bus stays untouched until accepted;
        // a redirect only marks its eventual response as stale.
        if (redirect_valid) begin
          w_kill_next = 1'b1;
        end
        if (imem_req_ready) begin
          w_state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (r_kill || redirect_valid) begin
            // Stale response: discard it and refetch from the current PC.
            w_kill_next  = 1'b0;
            w_req_load   = 1'b1;
            w_state_next = w_fetch_state;
          end else begin
            w_capture    = 1'b1;
            w_state_next = S_FULL;
          end
        end else if (redirect_valid) begin
          w_kill_next = 1'b1;
        end
      end

      S_FULL: begin
        // A redirect also empties the buffer: the jump that produced it was
        // consumed by execute in this same cycle.
        if (out_ready || redirect_valid) begin
          w_pc_next       = redirect_valid ? w_redirect_pc : w_seq_pc;
          w_req_addr_next = w_pc_next;
          w_req_load      = 1'b1;
          w_state_next    = w_fetch_state;
        end
      end

      S_HALTED: begin
        w_state_next = S_HALTED;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_req_addr <= 64'd0;
      r_kill     <= 1'b0;
      r_halted   <= 1'b0;
      r_out_pc   <= 64'd0;
      r_out_inst <= 32'd0;
    end else begin
      r_pc   <= w_pc_next;
      r_kill <= w_kill_next;
      if (halt) begin
        r_halted <= 1'b1;
      end
      if (w_req_load) begin
        r_req_addr <= w_req_addr_next;
      end
      if (w_capture) begin
        r_out_pc   <= r_req_addr;
        r_out_inst <= imem_resp_data;
      end
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_req_addr;
  assign out_valid      = (r_state == S_FULL);
  assign out_pc         = r_out_pc;
  assign out_inst       = r_out_inst;

endmodule

// File: tb/tb_ysyx_22040237_ifu.sv
// tb/tb_ysyx_22040237_ifu.sv - scoreboard testbench for ysyx_22040237_ifu

module tb_ysyx_22040237_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;

  int checks   = 0;
  int errors   = 0;
  int resp_lat = 1;

  logic [63:0] exp_req[$];
  logic [95:0] exp_out[$];

  ysyx_22040237_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents: 0x80000000 holds 0x00100513.
  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return 32'h00100513 + {a[23:0], 8'h00};
  endfunction

  // Memory responder: answers each accepted request resp_lat cycles later.
  initial begin : responder
    logic        hs;
    logic [63:0] a;
    logic [63:0] paddr;
    int          cnt;
    cnt = 0;
    paddr = 64'd0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    forever begin
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready && rst_n;
      a  = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (hs) begin
        paddr = a;
        cnt   = resp_lat;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = inst_of(paddr);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold rules.
  initial begin : monitor
    logic        pv_out;
    logic        pv_req;
    logic [63:0] p_pc;
    logic [31:0] p_inst;
    logic [63:0] p_addr;
    logic [63:0] e_req;
    logic [95:0] e_out;
    pv_out = 1'b0;
    pv_req = 1'b0;
    p_pc   = 64'd0;
    p_inst = 32'd0;
    p_addr = 64'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv_out = 1'b0;
        pv_req = 1'b0;
        continue;
      end
      if (pv_out) begin
        checks++;
        if (!(out_valid && out_pc == p_pc && out_inst == p_inst)) begin
          errors++;
          $display("FAIL out_hold act v=%0b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                   out_valid, out_pc, out_inst, p_pc, p_inst);
        end
      end
      if (pv_req) begin
        checks++;
        if (!(imem_req_valid && imem_req_addr == p_addr)) begin
          errors++;
          $display("FAIL req_hold act v=%0b addr=%h exp v=1 addr=%h",
                   imem_req_valid, imem_req_addr, p_addr);
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected act addr=%h exp no request", imem_req_addr);
        end else begin
          e_req = exp_req.pop_front();
          if (imem_req_addr !== e_req) begin
            errors++;
            $display("FAIL req_addr act=%h exp=%h", imem_req_addr, e_req);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected act pc=%h inst=%h exp no output", out_pc, out_inst);
        end else begin
          e_out = exp_out.pop_front();
          if ({out_pc, out_inst} !== e_out) begin
            errors++;
            $display("FAIL out_data act pc=%h inst=%h exp pc=%h inst=%h",
                     out_pc, out_inst, e_out[95:32], e_out[31:0]);
          end
        end
      end
      pv_out = out_valid && !out_ready && !redirect_valid;
      pv_req = imem_req_valid && !imem_req_ready;
      p_pc   = out_pc;
      p_inst = out_inst;
      p_addr = imem_req_addr;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push_out(input logic [63:0] pc);
    exp_out.push_back({pc, inst_of(pc)});
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ordy, input logic mrdy, input int lat);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    halt           = 1'b0;
    out_ready      = ordy;
    imem_req_ready = mrdy;
    resp_lat       = lat;
    exp_req.delete();
    exp_out.delete();
    settle(4);
    @(negedge clk);
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_req_addr", imem_req_addr, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic end_test(input string tag);
    chk({tag, "_req_left"}, 64'(exp_req.size()), 64'd0);
    chk({tag, "_out_left"}, 64'(exp_out.size()), 64'd0);
  endtask

  task automatic wait_req_hs(input bit no_out, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(imem_req_valid && imem_req_ready)) begin
      if (no_out) chk({tag, "_no_out"}, {63'd0, out_valid}, 64'd0);
      n++;
      if (n > 60) begin
        checks++;
        errors++;
        $display("FAIL %s_hs_timeout act no request handshake exp handshake", tag);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid) begin
      n++;
      if (n > 60) begin
        checks++;
        errors++;
        $display("FAIL %s_out_timeout act out_valid=0 exp out_valid=1", tag);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : sequencer
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    halt           = 1'b0;

    // Basic fetch and backpressure in FULL.
    do_reset(1'b0, 1'b1, 1);
    exp_req.push_back(64'h8000_0000);
    push_out(64'h8000_0000);
    release_reset();
    wait_out_valid("t1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
      chk("t2_out_pc", out_pc, 64'h8000_0000);
      chk("t2_out_inst", {32'd0, out_inst}, 64'h0010_0513);
      chk("t2_no_req", {63'd0, imem_req_valid}, 64'd0);
    end
    exp_req.push_back(64'h8000_0004);
    push_out(64'h8000_0004);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_req_hs(1'b0, "t2");
    imem_req_ready = 1'b0;
    settle(6);
    end_test("t2");

    // Redirect while waiting for the response.
    do_reset(1'b1, 1'b1, 3);
    exp_req.push_back(64'h8000_0000);
    release_reset();
    wait_req_hs(1'b0, "t3a");
    exp_req.push_back(64'h8000_0100);
    push_out(64'h8000_0100);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_req_hs(1'b1, "t3b");
    imem_req_ready = 1'b0;
    settle(8);
    end_test("t3");

    // Consume and redirect in the same FULL cycle.
    do_reset(1'b0, 1'b1, 1);
    exp_req.push_back(64'h8000_0000);
    push_out(64'h8000_0000);
    exp_req.push_back(64'h8000_0200);
    push_out(64'h8000_0200);
    release_reset();
    wait_out_valid("t4");
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_req_hs(1'b0, "t4");
    imem_req_ready = 1'b0;
    settle(6);
    end_test("t4");

    // Redirect during a stalled request.
    do_reset(1'b1, 1'b0, 1);
    exp_req.push_back(64'h8000_0000);
    exp_req.push_back(64'h8000_0040);
    push_out(64'h8000_0040);
    release_reset();
    begin
      int n = 0;
      @(negedge clk);
      while (!imem_req_valid && n < 20) begin
        n++;
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_req_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("t5_req_addr", imem_req_addr, 64'h8000_0000);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
    end
    imem_req_ready = 1'b1;
    wait_req_hs(1'b0, "t5a");
    wait_req_hs(1'b1, "t5b");
    imem_req_ready = 1'b0;
    settle(6);
    end_test("t5");

    // Halt during WAIT: the in-flight instruction is still delivered.
    do_reset(1'b1, 1'b1, 2);
    exp_req.push_back(64'h8000_0000);
    push_out(64'h8000_0000);
    release_reset();
    wait_req_hs(1'b0, "t6");
    halt = 1'b1;
    @(posedge clk);
    #1;
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_halted_no_req", {63'd0, imem_req_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    end_test("t6");

    // Reset in the middle of WAIT: the late response is ignored.
    do_reset(1'b1, 1'b1, 3);
    exp_req.push_back(64'h8000_0000);
    release_reset();
    wait_req_hs(1'b0, "t6r");
    rst_n = 1'b0;
    exp_req.push_back(64'h8000_0000);
    push_out(64'h8000_0000);
    @(negedge clk);
    chk("t6r_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("t6r_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t6r_req_addr", imem_req_addr, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_req_hs(1'b1, "t6r");
    imem_req_ready = 1'b0;
    settle(8);
    end_test("t6r");

    // PC wrap from the top of the address space to zero.
    do_reset(1'b0, 1'b1, 1);
    exp_req.push_back(64'h8000_0000);
    push_out(64'h8000_0000);
    exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    push_out(64'hFFFF_FFFF_FFFF_FFFC);
    exp_req.push_back(64'd0);
    release_reset();
    wait_out_valid("t7");
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    wait_req_hs(1'b0, "t7a");
    wait_req_hs(1'b0, "t7b");
    out_ready      = 1'b0;
    imem_req_ready = 1'b0;
    settle(4);
    @(negedge clk);
    chk("t7_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t7_out_pc", out_pc, 64'd0);
    chk("t7_out_inst", {32'd0, out_inst}, {32'd0, inst_of(64'd0)});
    end_test("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
